// File: rtl/display_pkg.sv
// Shared types and active-low segment codes for the BCD display scanner.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package display_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    localparam seg_t SEG_0    = 7'h40;
    localparam seg_t SEG_1    = 7'h79;
    localparam seg_t SEG_2    = 7'h24;
    localparam seg_t SEG_3    = 7'h30;
    localparam seg_t SEG_4    = 7'h19;
    localparam seg_t SEG_5    = 7'h12;
    localparam seg_t SEG_6    = 7'h02;
    localparam seg_t SEG_7    = 7'h78;
    localparam seg_t SEG_8    = 7'h00;
    localparam seg_t SEG_9    = 7'h10;
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bus between the decade counters / display and the scanner.
// master: drives digits_in, load; slave (scanner): drives an, seg, slot_idx.
interface bcd_display_scanner_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg;
    logic [IDX_W-1:0]        slot_idx;

    modport master (
        output digits_in,
        output load,
        input  an,
        input  seg,
        input  slot_idx
    );

    modport slave (
        input  digits_in,
        input  load,
        output an,
        output seg,
        output slot_idx
    );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes A..F show a dash.
// Ports: bcd_i (4-bit digit), seg_o ({g,f,e,d,c,b,a}, active-low).
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner for a chain of BCD digits,
// with snapshot shadow register, leading-zero blanking and ghost blanking.
// Ports: clk, rst (sync, active-high), bus (slave: digits_in, load in;
// an active-low anodes, seg active-low segments, slot_idx out; all registered).
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_CYCLES  = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    bcd_display_scanner_if.slave        bus
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DW-1:0]         shadow_q, shadow_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    phase_e                phase_q, phase_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg_t                  seg_q, seg_d;
    logic [IDX_W-1:0]      slot_q, slot_d;

    logic                  wrap;
    logic [3:0]            digit;
    logic [IDX_W-1:0]      hi;
    logic                  suppress;
    seg_t                  dec_seg;

    assign wrap = (pre_q == PRE_LAST);

    // Snapshot, prescaler and slot index
    always_comb begin
        shadow_d = shadow_q;
        if (bus.load) begin
            shadow_d = bus.digits_in;
        end

        pre_d = pre_q + PRE_W'(1);
        if (wrap) begin
            pre_d = '0;
        end

        idx_d = idx_q;
        if (wrap) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Phase FSM: tracks pre_cnt so phase_q == (pre_q < BLANK_CYCLES ? BLANK : DRIVE)
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_BLANK: begin
                if (pre_d >= PRE_BLANK) begin
                    phase_d = PH_DRIVE;
                end
            end
            PH_DRIVE: begin
                if (wrap) begin
                    phase_d = PH_BLANK;
                end
            end
        endcase
    end

    // Digit mux plus index of the highest nonzero digit (0 when all zero)
    always_comb begin
        digit = 4'd0;
        hi    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit = shadow_q[4*k +: 4];
            end
            if (shadow_q[4*k +: 4] != 4'd0) begin
                hi = IDX_W'(k);
            end
        end
    end

    // idx 0 can never exceed hi, so digit 0 is always shown
    assign suppress = (BLANK_LEADING != 0) && (idx_q > hi);

    bcd_to_seg u_dec (
        .bcd_i (digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d   = '1;
        seg_d  = SEG_OFF;
        slot_d = idx_q;
        if (phase_q == PH_DRIVE && !suppress) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            phase_q  <= PH_BLANK;
            an_q     <= '1;
            seg_q    <= SEG_OFF;
            slot_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            slot_q   <= slot_d;
        end
    end

    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
    assign bus.slot_idx = slot_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (4 digits, 4-cycle slots, 1 blank).
// cyc counts edges since reset release; output after edge n shows slot state n-1.
module tb_bcd_display_scanner;
    import display_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    bcd_display_scanner_if #(.NUM_DIGITS(4)) bus ();

    bcd_display_scanner #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (4),
        .BLANK_CYCLES  (1),
        .BLANK_LEADING (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        bus.digits_in = 16'h0000;
        bus.load      = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.slot_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_hold an=%b seg=%h slot=%0d want 1111/7f/0",
                     bus.an, bus.seg, bus.slot_idx);
        end
        rst = 1'b0;
        cyc = 0;
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
            failures++;
            $display("FAIL reset_release an=%b seg=%h want 1111/7f", bus.an, bus.seg);
        end
        tick();
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.slot_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_blank an=%b seg=%h slot=%0d want 1111/7f/0",
                     bus.an, bus.seg, bus.slot_idx);
        end
        tick();
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h40 || bus.slot_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_drive an=%b seg=%h slot=%0d want 1110/40/0",
                     bus.an, bus.seg, bus.slot_idx);
        end
    endtask

    task automatic test_scan_1234();
        seg_t       tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [3:0] one = 4'b0001;
        logic [3:0] ea;
        seg_t       es;
        int         p, s;
        bus.digits_in = 16'h1234;
        bus.load      = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p  = (cyc - 1) % 4;
            s  = ((cyc - 1) / 4) % 4;
            ea = (p == 0) ? 4'hF : ~(one << s);
            es = (p == 0) ? 7'h7F : tab[s];
            checks++;
            if (bus.an !== ea || bus.seg !== es || bus.slot_idx !== 2'(s)) begin
                failures++;
                $display("FAIL scan_1234 cyc=%0d an=%b seg=%h slot=%0d want %b/%h/%0d",
                         cyc, bus.an, bus.seg, bus.slot_idx, ea, es, s);
            end
        end
    endtask

    task automatic test_leading_zero();
        seg_t       tab_a [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        seg_t       tab_b [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        logic [3:0] one = 4'b0001;
        logic [3:0] ea;
        seg_t       es;
        int         p, s;
        bus.digits_in = 16'h0050;
        bus.load      = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p  = (cyc - 1) % 4;
            s  = ((cyc - 1) / 4) % 4;
            ea = (p == 0 || tab_a[s] == 7'h7F) ? 4'hF : ~(one << s);
            es = (p == 0) ? 7'h7F : tab_a[s];
            checks++;
            if (bus.an !== ea || bus.seg !== es || bus.slot_idx !== 2'(s)) begin
                failures++;
                $display("FAIL lz_0050 cyc=%0d an=%b seg=%h slot=%0d want %b/%h/%0d",
                         cyc, bus.an, bus.seg, bus.slot_idx, ea, es, s);
            end
        end
        bus.digits_in = 16'h0000;
        bus.load      = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p  = (cyc - 1) % 4;
            s  = ((cyc - 1) / 4) % 4;
            ea = (p == 0 || tab_b[s] == 7'h7F) ? 4'hF : ~(one << s);
            es = (p == 0) ? 7'h7F : tab_b[s];
            checks++;
            if (bus.an !== ea || bus.seg !== es || bus.slot_idx !== 2'(s)) begin
                failures++;
                $display("FAIL lz_0000 cyc=%0d an=%b seg=%h slot=%0d want %b/%h/%0d",
                         cyc, bus.an, bus.seg, bus.slot_idx, ea, es, s);
            end
        end
    endtask

    task automatic test_invalid();
        seg_t       tab [4] = '{7'h78, 7'h3F, 7'h7F, 7'h7F};
        logic [3:0] one = 4'b0001;
        logic [3:0] ea;
        seg_t       es;
        int         p, s;
        bus.digits_in = 16'h00A7;
        bus.load      = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p  = (cyc - 1) % 4;
            s  = ((cyc - 1) / 4) % 4;
            ea = (p == 0 || tab[s] == 7'h7F) ? 4'hF : ~(one << s);
            es = (p == 0) ? 7'h7F : tab[s];
            checks++;
            if (bus.an !== ea || bus.seg !== es || bus.slot_idx !== 2'(s)) begin
                failures++;
                $display("FAIL invalid_00a7 cyc=%0d an=%b seg=%h slot=%0d want %b/%h/%0d",
                         cyc, bus.an, bus.seg, bus.slot_idx, ea, es, s);
            end
        end
    endtask

    // digits_in moves without load, then a load lands exactly on a wrap edge
    task automatic test_no_load_and_wrap_load();
        seg_t       tab_old [4] = '{7'h78, 7'h3F, 7'h7F, 7'h7F};
        seg_t       tab_new [4] = '{7'h02, 7'h00, 7'h30, 7'h7F};
        logic [3:0] one = 4'b0001;
        logic [3:0] ea;
        seg_t       es;
        seg_t       t;
        int         p, s;
        int         start;
        int         cap = 1 << 30;
        bus.digits_in = 16'h9999;
        start         = cyc;
        for (int i = 0; i < 32; i++) begin
            tick();
            p  = (cyc - 1) % 4;
            s  = ((cyc - 1) / 4) % 4;
            t  = (cyc <= cap) ? tab_old[s] : tab_new[s];
            ea = (p == 0 || t == 7'h7F) ? 4'hF : ~(one << s);
            es = (p == 0) ? 7'h7F : t;
            checks++;
            if (bus.an !== ea || bus.seg !== es || bus.slot_idx !== 2'(s)) begin
                failures++;
                $display("FAIL wrap_load cyc=%0d an=%b seg=%h slot=%0d want %b/%h/%0d",
                         cyc, bus.an, bus.seg, bus.slot_idx, ea, es, s);
            end
            if (bus.load) begin
                bus.load = 1'b0;
            end else if (cap > cyc && cyc >= start + 16 && cyc % 4 == 3) begin
                bus.digits_in = 16'h0386;
                bus.load      = 1'b1;
                cap           = cyc + 1;
            end
        end
    endtask

    task automatic test_mid_reset();
        seg_t       tab_new [4] = '{7'h02, 7'h00, 7'h30, 7'h7F};
        seg_t       tab_z   [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        logic [3:0] one = 4'b0001;
        logic [3:0] ea;
        seg_t       es;
        int         p, s;
        for (int i = 0; i < 16 && cyc < 107; i++) begin
            tick();
        end
        checks++;
        if (bus.an !== 4'b1011 || bus.seg !== 7'h30 || bus.slot_idx !== 2'd2) begin
            failures++;
            $display("FAIL mid_slot2 an=%b seg=%h slot=%0d want 1011/30/2 (%h)",
                     bus.an, bus.seg, bus.slot_idx, tab_new[2]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.slot_idx !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset an=%b seg=%h slot=%0d want 1111/7f/0",
                     bus.an, bus.seg, bus.slot_idx);
        end
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p  = (cyc - 1) % 4;
            s  = ((cyc - 1) / 4) % 4;
            ea = (p == 0 || tab_z[s] == 7'h7F) ? 4'hF : ~(one << s);
            es = (p == 0) ? 7'h7F : tab_z[s];
            checks++;
            if (bus.an !== ea || bus.seg !== es || bus.slot_idx !== 2'(s)) begin
                failures++;
                $display("FAIL post_reset cyc=%0d an=%b seg=%h slot=%0d want %b/%h/%0d",
                         cyc, bus.an, bus.seg, bus.slot_idx, ea, es, s);
            end
        end
    endtask

    initial begin
        bus.digits_in = 16'h0000;
        bus.load      = 1'b0;
        test_reset();
        test_scan_1234();
        test_leading_zero();
        test_invalid();
        test_no_load_and_wrap_load();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
